// File: rtl/divider_pkg.sv
// Shared constants for the iterative divider: state encodings, bus widths, result zero
// value and the start levels used by stage_ex.
package divider_pkg;

   localparam int DIV_WIDTH        = 32;
   localparam int DIV_COUNT_WIDTH  = 6;
   localparam int DIV_RESULT_WIDTH = 2 * DIV_WIDTH;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'd0,
      DIV_BY_ZERO = 2'd1,
      DIV_ON      = 2'd2,
      DIV_END     = 2'd3
   } div_state_t;

   localparam logic [DIV_RESULT_WIDTH-1:0] DIV_RESULT_ZERO = {DIV_RESULT_WIDTH{1'b0}};

   localparam logic DIV_START = 1'b1;
   localparam logic DIV_STOP  = 1'b0;

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift one dividend bit into the partial remainder,
// then subtract the divisor when that does not borrow.
module divider_step
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0]   shifted_s;
   logic [WIDTH+1:0] diff_s;

   // shift, trial subtract, restore on borrow
   always_comb begin
      shifted_s = {rem_in, bit_in};
      diff_s    = {1'b0, shifted_s} - {2'b00, divisor};
      q_bit     = ~diff_s[WIDTH+1];
      if (q_bit) begin
         rem_out = diff_s[WIDTH-1:0];
      end else begin
         rem_out = shifted_s[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU; result = {remainder, quotient}.
// Define DIVIDER_EARLY_EXIT_EN to finish early when |dividend| < |divisor|.
module divider
   import divider_pkg::*;
#(
   parameter int WIDTH       = DIV_WIDTH,
   parameter int COUNT_WIDTH = DIV_COUNT_WIDTH
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               cancel,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   operand_a,
   input  logic [WIDTH-1:0]   operand_b,
   output logic [2*WIDTH-1:0] result,
   output logic               ready
);

   localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(WIDTH - 1);

   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
      if (neg) begin
         neg_if = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         neg_if = v;
      end
   endfunction

   div_state_t             state_r, state_next_s;
   logic [COUNT_WIDTH-1:0] count_r;
   logic [WIDTH-1:0]       rem_r, quo_r, div_r;
   logic                   sign_a_r, sign_b_r, signed_r, early_r;
   logic [2*WIDTH-1:0]     result_r;
   logic                   ready_r;

   logic [WIDTH-1:0] abs_a_s, abs_b_s, step_rem_s, q_raw_s, r_raw_s, q_fix_s, r_fix_s;
   logic             step_q_s, early_s, load_s, step_s, finish_s, zero_s;

   // operand magnitudes and the early-exit test, evaluated while FREE
   always_comb begin
      abs_a_s = neg_if(operand_a, signed_div & operand_a[WIDTH-1]);
      abs_b_s = neg_if(operand_b, signed_div & operand_b[WIDTH-1]);
`ifdef DIVIDER_EARLY_EXIT_EN
      early_s = (abs_a_s < abs_b_s);
`else
      early_s = 1'b0;
`endif
   end

   divider_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_r),
      .bit_in  (quo_r[WIDTH-1]),
      .divisor (div_r),
      .rem_out (step_rem_s),
      .q_bit   (step_q_s)
   );

   // state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= DIV_FREE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // next-state logic; cancel overrides everything
   always_comb begin
      state_next_s = state_r;
      if (cancel) begin
         state_next_s = DIV_FREE;
      end else begin
         case (state_r)
            DIV_FREE: begin
               if (start == DIV_START) begin
                  if (operand_b == {WIDTH{1'b0}}) begin
                     state_next_s = DIV_BY_ZERO;
                  end else begin
                     state_next_s = DIV_ON;
                  end
               end else begin
                  state_next_s = DIV_FREE;
               end
            end
            DIV_BY_ZERO: state_next_s = DIV_END;
            DIV_ON: begin
               if (early_r || (count_r == LAST_COUNT)) begin
                  state_next_s = DIV_END;
               end else begin
                  state_next_s = DIV_ON;
               end
            end
            DIV_END: begin
               if (start == DIV_START) begin
                  state_next_s = DIV_END;
               end else begin
                  state_next_s = DIV_FREE;
               end
            end
            default: state_next_s = DIV_FREE;
         endcase
      end
   end

   // datapath controls decoded from the current state
   always_comb begin
      load_s   = 1'b0;
      step_s   = 1'b0;
      finish_s = 1'b0;
      zero_s   = 1'b0;
      case (state_r)
         DIV_FREE:    load_s   = !cancel && (start == DIV_START) && (operand_b != {WIDTH{1'b0}});
         DIV_BY_ZERO: zero_s   = !cancel;
         DIV_ON: begin
            step_s   = !cancel && !early_r;
            finish_s = !cancel && (early_r || (count_r == LAST_COUNT));
         end
         DIV_END:     load_s   = 1'b0;
         default:     load_s   = 1'b0;
      endcase
   end

   // final magnitudes, then sign correction applied on entry to END
   always_comb begin
      if (early_r) begin
         q_raw_s = {WIDTH{1'b0}};
         r_raw_s = quo_r;
      end else begin
         q_raw_s = {quo_r[WIDTH-2:0], step_q_s};
         r_raw_s = step_rem_s;
      end
      q_fix_s = neg_if(q_raw_s, signed_r & (sign_a_r ^ sign_b_r));
      r_fix_s = neg_if(r_raw_s, signed_r & sign_a_r);
   end

   // iteration registers, result and ready
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_r  <= {COUNT_WIDTH{1'b0}};
         rem_r    <= {WIDTH{1'b0}};
         quo_r    <= {WIDTH{1'b0}};
         div_r    <= {WIDTH{1'b0}};
         sign_a_r <= 1'b0;
         sign_b_r <= 1'b0;
         signed_r <= 1'b0;
         early_r  <= 1'b0;
         result_r <= {(2*WIDTH){1'b0}};
         ready_r  <= 1'b0;
      end else begin
         ready_r <= (state_next_s == DIV_END);
         if (cancel) begin
            result_r <= {(2*WIDTH){1'b0}};
            count_r  <= {COUNT_WIDTH{1'b0}};
            early_r  <= 1'b0;
         end else if (load_s) begin
            quo_r    <= abs_a_s;
            div_r    <= abs_b_s;
            rem_r    <= {WIDTH{1'b0}};
            count_r  <= {COUNT_WIDTH{1'b0}};
            sign_a_r <= operand_a[WIDTH-1];
            sign_b_r <= operand_b[WIDTH-1];
            signed_r <= signed_div;
            early_r  <= early_s;
         end else if (step_s || finish_s) begin
            rem_r   <= step_rem_s;
            quo_r   <= {quo_r[WIDTH-2:0], step_q_s};
            count_r <= count_r + COUNT_WIDTH'(1);
            if (finish_s) begin
               result_r <= {r_fix_s, q_fix_s};
            end
         end else if (zero_s) begin
            result_r <= {(2*WIDTH){1'b0}};
         end
      end
   end

   assign result = result_r;
   assign ready  = ready_r;

endmodule
